// File: rtl/rs485_dir_arb.sv
// -----------------------------------------------------------------------------
// rs485_dir_arb
//
// Half-duplex RS-485 direction arbiter for two local requesters. The bus must
// be idle (rx high) for IDLE_CNT consecutive cycles before we drive it. A
// transfer then runs through three phases:
//   PRE   : driver enabled, bus held at mark (tx=1) for PRE_CNT cycles
//   GRANT : winner's serial data is registered onto tx
//   POST  : driver still enabled, bus held at mark for POST_CNT cycles
// A round-robin pointer breaks ties between simultaneous requests. It flips to
// favour the other requester every time a transfer ends, including aborts and
// timeouts.
//
// Parameters
//   IDLE_CNT  : idle-high cycles needed before driving     (1..65535)
//   PRE_CNT   : preamble cycles before the grant           (1..65535)
//   POST_CNT  : trailing mark cycles after release         (1..65535)
//   MAX_GRANT : grant length in cycles before forced release (1..65535)
//
// Ports
//   clk     : clock, rising edge
//   reset_n : asynchronous active-low reset
//   rx      : bus receive line (asynchronous, idle high)
//   req     : per-requester transmit request, held for the whole transfer
//   txd0/1  : serial data from requester 0 / 1
//   gnt     : one-hot grant
//   tx      : registered bus transmit data
//   tx_en   : registered driver enable
//   busy    : high whenever the arbiter is not in IDLE
//   timeout : one-cycle pulse when a grant is cut off at MAX_GRANT
// -----------------------------------------------------------------------------
module rs485_dir_arb #(
    parameter int IDLE_CNT  = 10,
    parameter int PRE_CNT   = 2,
    parameter int POST_CNT  = 2,
    parameter int MAX_GRANT = 1024
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx,
    input  logic [1:0] req,
    input  logic       txd0,
    input  logic       txd1,
    output logic [1:0] gnt,
    output logic       tx,
    output logic       tx_en,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRE   = 2'd1,
        GRANT = 2'd2,
        POST  = 2'd3
    } state_t;

    // Phase counters count down to zero, so they are loaded with N-1 to give
    // exactly N cycles in the phase.
    localparam logic [15:0] IDLE_MAX  = 16'(IDLE_CNT);
    localparam logic [15:0] PRE_LOAD  = 16'(PRE_CNT - 1);
    localparam logic [15:0] POST_LOAD = 16'(POST_CNT - 1);
    localparam logic [15:0] GRANT_MAX = 16'(MAX_GRANT);

    state_t      state_reg;
    logic        rx_meta_reg;
    logic        rx_s_reg;
    logic [15:0] idle_cnt_reg;
    logic [15:0] phase_cnt_reg;
    logic [15:0] grant_cnt_reg;
    logic        rr_reg;
    logic        winner_reg;
    logic [1:0]  gnt_reg;
    logic        tx_reg;
    logic        tx_en_reg;
    logic        timeout_reg;

    logic        winner_next;
    logic        req_w;
    logic        txd_w;

    // Two-flop synchronizer; resets to the idle (high) level so the bus does
    // not look active straight out of reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta_reg <= 1'b1;
            rx_s_reg    <= 1'b1;
        end else begin
            rx_meta_reg <= rx;
            rx_s_reg    <= rx_meta_reg;
        end
    end

    // Idle detector. Our own driving (tx_en) also clears it, so after every
    // transfer the bus has to be seen idle for a fresh IDLE_CNT cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idle_cnt_reg <= 16'd0;
        end else if (!rx_s_reg || tx_en_reg) begin
            idle_cnt_reg <= 16'd0;
        end else if (idle_cnt_reg != IDLE_MAX) begin
            idle_cnt_reg <= idle_cnt_reg + 16'd1;
        end
    end

    // Winner choice: a lone requester wins outright, a tie goes to rr_reg.
    always_comb begin
        winner_next = rr_reg;
        case (req)
            2'b01:   winner_next = 1'b0;
            2'b10:   winner_next = 1'b1;
            default: winner_next = rr_reg;
        endcase
    end

    // Once latched, only the winner's request and data are looked at.
    assign req_w = winner_reg ? req[1] : req[0];
    assign txd_w = winner_reg ? txd1 : txd0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            phase_cnt_reg <= 16'd0;
            grant_cnt_reg <= 16'd0;
            rr_reg        <= 1'b0;
            winner_reg    <= 1'b0;
            gnt_reg       <= 2'b00;
            tx_reg        <= 1'b1;
            tx_en_reg     <= 1'b0;
            timeout_reg   <= 1'b0;
        end else begin
            timeout_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if ((req != 2'b00) && (idle_cnt_reg == IDLE_MAX)) begin
                        winner_reg    <= winner_next;
                        tx_en_reg     <= 1'b1;
                        tx_reg        <= 1'b1;
                        phase_cnt_reg <= PRE_LOAD;
                        state_reg     <= PRE;
                    end
                end

                PRE: begin
                    if (!req_w) begin
                        // Requester gave up before its grant: still finish
                        // with a clean POST so the line settles at mark.
                        phase_cnt_reg <= POST_LOAD;
                        state_reg     <= POST;
                    end else if (phase_cnt_reg == 16'd0) begin
                        gnt_reg       <= winner_reg ? 2'b10 : 2'b01;
                        grant_cnt_reg <= 16'd1;
                        state_reg     <= GRANT;
                    end else begin
                        phase_cnt_reg <= phase_cnt_reg - 16'd1;
                    end
                end

                GRANT: begin
                    if (!req_w) begin
                        gnt_reg       <= 2'b00;
                        tx_reg        <= 1'b1;
                        phase_cnt_reg <= POST_LOAD;
                        state_reg     <= POST;
                    end else if (grant_cnt_reg == GRANT_MAX) begin
                        // grant_cnt_reg counts the cycle gnt went high as 1,
                        // so gnt is high for exactly MAX_GRANT cycles.
                        gnt_reg       <= 2'b00;
                        timeout_reg   <= 1'b1;
                        tx_reg        <= 1'b1;
                        phase_cnt_reg <= POST_LOAD;
                        state_reg     <= POST;
                    end else begin
                        grant_cnt_reg <= grant_cnt_reg + 16'd1;
                        tx_reg        <= txd_w;
                    end
                end

                POST: begin
                    if (phase_cnt_reg == 16'd0) begin
                        tx_en_reg <= 1'b0;
                        rr_reg    <= ~winner_reg;
                        state_reg <= IDLE;
                    end else begin
                        phase_cnt_reg <= phase_cnt_reg - 16'd1;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign gnt     = gnt_reg;
    assign tx      = tx_reg;
    assign tx_en   = tx_en_reg;
    assign timeout = timeout_reg;
    assign busy    = (state_reg != IDLE);

endmodule
